multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Parametrised successor to the multicycle MIPS main decoder: Moore control FSM driving the shared-memory datapath (PC, IR, ALU, register file).
- Adds BNE, ANDI, ORI and J to LW/SW/R-type/BEQ/ADDI.
- Adds an optional memory-ready handshake with wait states, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register's opcode field and the datapath control inputs; the ALU decoder consumes ALUOp.

Parameters:
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMRD/MEMWR wait for MemReady; 0 = MemReady ignored, treated as 1.
- EXT_OPS, 1: 1 = BNE/ANDI/ORI/J decoded; 0 = those opcodes are illegal.
- CNT_W, 16: width of InstrCount.

Ports:
- Clk input 1: clock, rising edge.
- Reset input 1: asynchronous, active-low reset.
- Opcode input 6: IR[31:26], valid from DECODE onward.
- MemReady input 1: memory access complete this cycle.
- MemtoReg output 1: register writeback source (1 = Data register).
- MemWrite output 1: memory write strobe.
- RegDst output 1: 1 = rd, 0 = rt.
- RegWrite output 1: register file write strobe.
- IorD output 1: memory address source (1 = ALUOut).
- ALUSrcA output 1: 1 = register A, 0 = PC.
- ALUSrcB output 2: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp output 3: 000 add, 001 sub, 010 funct, 011 and, 100 or.
- ZeroExt output 1: immediate zero-extended (ANDI/ORI).
- PCSrc output 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- IRWrite output 1: IR load strobe.
- PCWrite output 1: unconditional PC write.
- Branch output 1: PC write if Zero.
- BranchNe output 1: PC write if !Zero.
- IllegalOp output 1: one-cycle pulse on an unsupported opcode.
- State output 4: current state encoding, for debug.
- InstrCount output CNT_W: count of retired instructions.

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, IWB 10, JEX 11, BNEEX 12, ANDIEX 13, ORIEX 14, ILLEGAL 15.
- Reset low (asynchronous): State = FETCH and InstrCount = 0.
  - While Reset is low, IRWrite, PCWrite, MemWrite, RegWrite, Branch, BranchNe and IllegalOp are forced to 0.
  - All other outputs hold their FETCH values.
- Outputs are a pure function of State (Moore), except FETCH's IRWrite/PCWrite, which are ANDed with the effective MemReady. Unlisted outputs are 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00, IRWrite=PCWrite=effective MemReady.
  - Stays in FETCH while effective MemReady=0, otherwise goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by Opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000101 -> BNEEX (EXT_OPS only)
  - 001100 -> ANDIEX (EXT_OPS only)
  - 001101 -> ORIEX (EXT_OPS only)
  - 000010 -> JEX (EXT_OPS only)
  - anything else -> ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Goes to MEMRD if the opcode is LW, MEMWR if SW.
- MEMRD: IorD=1. Waits for effective MemReady, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=1 held until effective MemReady. Then goes to FETCH.
  - The write is counted once regardless of wait length.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Goes to RTWB.
- RTWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01, Branch=1. Goes to FETCH.
- BNEEX: as BEQEX, but BranchNe=1 and Branch=0.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Goes to IWB.
- ANDIEX: as ADDIEX with ALUOp=011 and ZeroExt=1.
- ORIEX: as ADDIEX with ALUOp=100 and ZeroExt=1.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1. Goes to FETCH.
- JEX: PCSrc=10, PCWrite=1. Goes to FETCH.
- ILLEGAL: IllegalOp=1 for exactly one cycle, no writes. Goes to FETCH; the PC has already advanced by 4.
- InstrCount:
  - Increments by 1 on every clock edge that moves State from MEMWB, MEMWR (with ready), RTWB, BEQEX, BNEEX, IWB or JEX to FETCH.
  - Wraps modulo 2^CNT_W.
  - ILLEGAL does not count.
- Reset asserted mid-instruction (any state, including a wait state) aborts immediately. No partial strobe survives the reset edge.
- Wait-state timing: with MEM_HANDSHAKE=0, LW takes 5 cycles, SW 4, R-type/ADDI/ANDI/ORI 4, BEQ/BNE/J 3. Each MemReady-low cycle in FETCH/MEMRD/MEMWR adds one cycle.

Test Plan:
- Reset low for 10 ns, MemReady=1, Opcode=000000 -> State 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. InstrCount=1 after the first return to FETCH.
- Opcode=100011, MemReady held 0 for 2 cycles in MEMRD -> State 0,1,2,3,3,3,4,0. MemtoReg=1 and RegWrite=1 in state 4 only. Total of 7 cycles.
- Opcode=101011, MemReady=0 for 3 FETCH cycles -> IRWrite=PCWrite=0 during the waits and 1 on the ready cycle. MemWrite=1 for every MEMWR cycle until ready. InstrCount increments by exactly 1.
- EXT_OPS=1, Opcode=000101 -> BNEEX with BranchNe=1, Branch=0, PCSrc=01, ALUOp=001. Opcode=000010 -> JEX with PCWrite=1, PCSrc=10.
- EXT_OPS=0, Opcode=001101 -> ILLEGAL. IllegalOp high for exactly one cycle, then FETCH. InstrCount unchanged.
- Reset driven low asynchronously mid-RTWB -> State=0 and RegWrite=0 before the next Clk edge, InstrCount=0. CNT_W=4 with 16 retired R-types -> InstrCount wraps to 0.

Source files
------------

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the shared-memory datapath.
// master = FSM side (drives controls), slave = datapath/memory side.
interface multicycle_main_fsm_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Opcode;
  logic             MemReady;
  logic             MemtoReg;
  logic             MemWrite;
  logic             RegDst;
  logic             RegWrite;
  logic             IorD;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic             ZeroExt;
  logic [1:0]       PCSrc;
  logic             IRWrite;
  logic             PCWrite;
  logic             Branch;
  logic             BranchNe;
  logic             IllegalOp;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Opcode, MemReady,
    output MemtoReg, MemWrite, RegDst, RegWrite, IorD, ALUSrcA, ALUSrcB, ALUOp,
           ZeroExt, PCSrc, IRWrite, PCWrite, Branch, BranchNe, IllegalOp,
           State, InstrCount
  );

  modport slave (
    output Opcode, MemReady,
    input  MemtoReg, MemWrite, RegDst, RegWrite, IorD, ALUSrcA, ALUSrcB, ALUOp,
           ZeroExt, PCSrc, IRWrite, PCWrite, Branch, BranchNe, IllegalOp,
           State, InstrCount
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Moore main control FSM for the multicycle MIPS datapath, with optional memory
// wait states, illegal-opcode trap and a retired-instruction counter.
module multicycle_main_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int EXT_OPS       = 1,
  parameter int CNT_W         = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  multicycle_main_fsm_if.master       bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, RTEX = 4'd6, RTWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9,
    IWB = 4'd10, JEX = 4'd11, BNEEX = 4'd12, ANDIEX = 4'd13, ORIEX = 4'd14,
    ILLEGAL = 4'd15
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_J = 6'b000010;
  localparam bit EXT = (EXT_OPS != 0);

  state_t st, ns;
  logic [CNT_W-1:0] cnt;
  logic rdy, retire;
  logic memtoreg, memwrite, regdst, regwrite, iord, alusrca, zeroext;
  logic irwrite, pcwrite, branch, branchne, illegalop;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;

  assign rdy = (MEM_HANDSHAKE != 0) ? bus.MemReady : 1'b1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st <= ns;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ns = st;
    retire = 1'b0;
    memtoreg = 1'b0; memwrite = 1'b0; regdst = 1'b0; regwrite = 1'b0;
    iord = 1'b0; alusrca = 1'b0; alusrcb = 2'b00; aluop = 3'b000;
    zeroext = 1'b0; pcsrc = 2'b00; irwrite = 1'b0; pcwrite = 1'b0;
    branch = 1'b0; branchne = 1'b0; illegalop = 1'b0;
    unique case (st)
      FETCH: begin
        alusrcb = 2'b01; irwrite = rdy; pcwrite = rdy;
        if (rdy) ns = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW: ns = MEMADR;
          OP_R:         ns = RTEX;
          OP_BEQ:       ns = BEQEX;
          OP_ADDI:      ns = ADDIEX;
          OP_BNE:       ns = EXT ? BNEEX  : ILLEGAL;
          OP_ANDI:      ns = EXT ? ANDIEX : ILLEGAL;
          OP_ORI:       ns = EXT ? ORIEX  : ILLEGAL;
          OP_J:         ns = EXT ? JEX    : ILLEGAL;
          default:      ns = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1; alusrcb = 2'b10;
        ns = (bus.Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (rdy) ns = MEMWB;
      end
      MEMWB: begin memtoreg = 1'b1; regwrite = 1'b1; ns = FETCH; retire = 1'b1; end
      // Store strobe stays up across wait states; it retires only on the ready cycle.
      MEMWR: begin
        iord = 1'b1; memwrite = 1'b1;
        if (rdy) begin ns = FETCH; retire = 1'b1; end
      end
      RTEX:   begin alusrca = 1'b1; aluop = 3'b010; ns = RTWB; end
      RTWB:   begin regdst = 1'b1; regwrite = 1'b1; ns = FETCH; retire = 1'b1; end
      BEQEX:  begin
        alusrca = 1'b1; aluop = 3'b001; pcsrc = 2'b01; branch = 1'b1;
        ns = FETCH; retire = 1'b1;
      end
      BNEEX:  begin
        alusrca = 1'b1; aluop = 3'b001; pcsrc = 2'b01; branchne = 1'b1;
        ns = FETCH; retire = 1'b1;
      end
      ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; ns = IWB; end
      ANDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; aluop = 3'b011; zeroext = 1'b1; ns = IWB; end
      ORIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; aluop = 3'b100; zeroext = 1'b1; ns = IWB; end
      IWB:    begin regwrite = 1'b1; ns = FETCH; retire = 1'b1; end
      JEX:    begin pcsrc = 2'b10; pcwrite = 1'b1; ns = FETCH; retire = 1'b1; end
      ILLEGAL: begin illegalop = 1'b1; ns = FETCH; end
      default: ns = FETCH;
    endcase
  end

  // Strobes are gated by Reset so none survives while it is asserted.
  assign bus.IRWrite   = irwrite   & Reset;
  assign bus.PCWrite   = pcwrite   & Reset;
  assign bus.MemWrite  = memwrite  & Reset;
  assign bus.RegWrite  = regwrite  & Reset;
  assign bus.Branch    = branch    & Reset;
  assign bus.BranchNe  = branchne  & Reset;
  assign bus.IllegalOp = illegalop & Reset;
  assign bus.MemtoReg  = memtoreg;
  assign bus.RegDst    = regdst;
  assign bus.IorD      = iord;
  assign bus.ALUSrcA   = alusrca;
  assign bus.ALUSrcB   = alusrcb;
  assign bus.ALUOp     = aluop;
  assign bus.ZeroExt   = zeroext;
  assign bus.PCSrc     = pcsrc;
  assign bus.State     = st;
  assign bus.InstrCount = cnt;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized check of the main control FSM against a per-instruction state-sequence model.
// dut_a: handshake + extended ops; dut_b: no handshake, base ops only, 4-bit counter.
module tb_multicycle_main_fsm;
  logic Clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  int n_tests = 0, n_fail = 0;
  int cnt [2];

  always #5 Clk = ~Clk;

  multicycle_main_fsm_if #(.CNT_W(16)) ifa ();
  multicycle_main_fsm_if #(.CNT_W(4))  ifb ();

  multicycle_main_fsm dut_a (.Clk(Clk), .Reset(rst_a), .bus(ifa));
  multicycle_main_fsm #(.MEM_HANDSHAKE(0), .EXT_OPS(0), .CNT_W(4))
    dut_b (.Clk(Clk), .Reset(rst_b), .bus(ifb));

  logic [18:0] ctl_a, ctl_b;
  assign ctl_a = {ifa.MemtoReg, ifa.MemWrite, ifa.RegDst, ifa.RegWrite, ifa.IorD, ifa.ALUSrcA,
                  ifa.ALUSrcB, ifa.ALUOp, ifa.ZeroExt, ifa.PCSrc, ifa.IRWrite, ifa.PCWrite,
                  ifa.Branch, ifa.BranchNe, ifa.IllegalOp};
  assign ctl_b = {ifb.MemtoReg, ifb.MemWrite, ifb.RegDst, ifb.RegWrite, ifb.IorD, ifb.ALUSrcA,
                  ifb.ALUSrcB, ifb.ALUOp, ifb.ZeroExt, ifb.PCSrc, ifb.IRWrite, ifb.PCWrite,
                  ifb.Branch, ifb.BranchNe, ifb.IllegalOp};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word for a state, straight from the per-state output table.
  function automatic logic [18:0] exp_ctl(input int s, input bit rdy);
    logic m2r, mw, rd, rw, iord, asa, zx, irw, pcw, br, bne, ill;
    logic [1:0] asb, pcs;
    logic [2:0] op;
    {m2r, mw, rd, rw, iord, asa, zx, irw, pcw, br, bne, ill} = '0;
    asb = 2'd0; pcs = 2'd0; op = 3'd0;
    case (s)
      0:  begin asb = 2'd1; irw = rdy; pcw = rdy; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; op = 3'd2; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; op = 3'd1; pcs = 2'd1; br = 1; end
      9:  begin asa = 1; asb = 2'd2; end
      10: rw = 1;
      11: begin pcs = 2'd2; pcw = 1; end
      12: begin asa = 1; op = 3'd1; pcs = 2'd1; bne = 1; end
      13: begin asa = 1; asb = 2'd2; op = 3'd3; zx = 1; end
      14: begin asa = 1; asb = 2'd2; op = 3'd4; zx = 1; end
      default: ill = 1;
    endcase
    return {m2r, mw, rd, rw, iord, asa, asb, op, zx, pcs, irw, pcw, br, bne, ill};
  endfunction

  int es[$];
  bit dr[$];
  bit er[$];

  task automatic push(input int s, input bit d, input bit e);
    es.push_back(s); dr.push_back(d); er.push_back(e);
  endtask

  // One instruction: build the expected per-cycle state list, then walk it.
  task automatic run_instr(input bit sel, input logic [5:0] op, input int fw, input int mw);
    bit hs, ext, ret;
    int lim;
    hs = !sel; ext = !sel; ret = 1'b1;
    es.delete(); dr.delete(); er.delete();
    if (hs) begin
      for (int k = 0; k < fw; k++) push(0, 1'b0, 1'b0);
      push(0, 1'b1, 1'b1);
    end else push(0, 1'($urandom_range(0, 1)), 1'b1);
    push(1, 1'($urandom_range(0, 1)), 1'b1);
    lim = hs ? mw : 0;
    case (op)
      6'd35: begin
        push(2, 1'b1, 1'b1);
        for (int k = 0; k < lim; k++) push(3, 1'b0, 1'b0);
        push(3, 1'b1, 1'b1); push(4, 1'b1, 1'b1);
      end
      6'd43: begin
        push(2, 1'b1, 1'b1);
        for (int k = 0; k < lim; k++) push(5, 1'b0, 1'b0);
        push(5, 1'b1, 1'b1);
      end
      6'd0:  begin push(6, 1'b1, 1'b1); push(7, 1'b1, 1'b1); end
      6'd4:  push(8, 1'b1, 1'b1);
      6'd8:  begin push(9, 1'b1, 1'b1); push(10, 1'b1, 1'b1); end
      6'd5:  if (ext) push(12, 1'b1, 1'b1); else begin push(15, 1'b1, 1'b1); ret = 0; end
      6'd12: if (ext) begin push(13, 1'b1, 1'b1); push(10, 1'b1, 1'b1); end
             else begin push(15, 1'b1, 1'b1); ret = 0; end
      6'd13: if (ext) begin push(14, 1'b1, 1'b1); push(10, 1'b1, 1'b1); end
             else begin push(15, 1'b1, 1'b1); ret = 0; end
      6'd2:  if (ext) push(11, 1'b1, 1'b1); else begin push(15, 1'b1, 1'b1); ret = 0; end
      default: begin push(15, 1'b1, 1'b1); ret = 0; end
    endcase
    for (int i = 0; i < es.size(); i++) begin
      @(negedge Clk);
      if (sel) begin ifb.Opcode = op; ifb.MemReady = dr[i]; end
      else begin ifa.Opcode = op; ifa.MemReady = dr[i]; end
      #1;
      if (sel) begin
        chk("b_state", 32'(ifb.State), 32'(es[i]));
        chk("b_ctl", 32'(ctl_b), 32'(exp_ctl(es[i], er[i])));
        if (i == 0) chk("b_count", 32'(ifb.InstrCount), 32'(cnt[1] % 16));
      end else begin
        chk("a_state", 32'(ifa.State), 32'(es[i]));
        chk("a_ctl", 32'(ctl_a), 32'(exp_ctl(es[i], er[i])));
        if (i == 0) chk("a_count", 32'(ifa.InstrCount), 32'(cnt[0] % 65536));
      end
    end
    if (ret) cnt[sel]++;
  endtask

  logic [5:0] ops [12];
  logic [5:0] rop;

  initial begin
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd5, 6'd12, 6'd13, 6'd2, 6'h3f, 6'h01, 6'h23};
    cnt[0] = 0; cnt[1] = 0;
    ifa.Opcode = 6'd0; ifa.MemReady = 1'b1;
    ifb.Opcode = 6'd0; ifb.MemReady = 1'b1;
    #2;
    chk("a_rst_state", 32'(ifa.State), 32'd0);
    chk("a_rst_ctl", 32'(ctl_a), 32'(exp_ctl(0, 1'b0)));
    chk("a_rst_count", 32'(ifa.InstrCount), 32'd0);
    chk("b_rst_ctl", 32'(ctl_b), 32'(exp_ctl(0, 1'b0)));
    ifa.MemReady = 1'b0;
    @(posedge Clk); #1 rst_a = 1'b1;

    // Directed walk through every instruction class with and without waits.
    run_instr(0, 6'd0, 0, 0);
    run_instr(0, 6'd35, 0, 2);
    run_instr(0, 6'd43, 3, 2);
    run_instr(0, 6'd5, 0, 0);
    run_instr(0, 6'd2, 1, 0);
    run_instr(0, 6'd4, 0, 0);
    run_instr(0, 6'd8, 0, 0);
    run_instr(0, 6'd12, 0, 0);
    run_instr(0, 6'd13, 2, 0);
    run_instr(0, 6'h3f, 0, 0);
    for (int n = 0; n < 60; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      run_instr(0, rop, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_instr(0, 6'd0, 0, 0);

    // Asynchronous reset in the middle of RTWB.
    for (int k = 0; k < 8 && ifa.State != 4'd7; k++) begin
      @(negedge Clk); ifa.Opcode = 6'd0; ifa.MemReady = 1'b1; #1;
    end
    chk("a_rtwb_reached", 32'(ifa.State), 32'd7);
    chk("a_rtwb_regwrite", 32'(ifa.RegWrite), 32'd1);
    #2 rst_a = 1'b0;
    #1;
    chk("a_midrst_state", 32'(ifa.State), 32'd0);
    chk("a_midrst_regwrite", 32'(ifa.RegWrite), 32'd0);
    chk("a_midrst_count", 32'(ifa.InstrCount), 32'd0);
    cnt[0] = 0;
    ifa.MemReady = 1'b0;
    @(posedge Clk); #1 rst_a = 1'b1;
    run_instr(0, 6'd43, 1, 1);
    run_instr(0, 6'd0, 0, 0);

    // Base-only, no-handshake, 4-bit-counter instance.
    @(posedge Clk); #1 rst_b = 1'b1;
    run_instr(1, 6'd13, 0, 0);
    run_instr(1, 6'd2, 0, 0);
    for (int n = 0; n < 16; n++) run_instr(1, 6'd0, 0, 0);
    run_instr(1, 6'd35, 3, 3);
    for (int n = 0; n < 25; n++) run_instr(1, ops[$urandom_range(0, 11)], 2, 2);
    run_instr(1, 6'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
